axi4_frame_read_ctrl: RTL and testbench

//   AXI4 read-master controller that fetches a 2-D frame (vsize lines x hsize beats, line pitch = stride).

---
 rtl/axi4_frame_read_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_axi4_frame_read_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_frame_read_ctrl.sv
// AXI4 read master that fetches a 2-D frame as INCR bursts and streams the R data out with line/frame markers.
// Optional: define AXI4_FRAME_READ_CTRL_4K_GUARD_EN to keep every burst inside one 4 KB page.
module axi4_frame_read_ctrl #(
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_LEN_WIDTH  = 8,
   parameter int AXI_DATA_SIZE  = 2,
   parameter int AXI_DATA_WIDTH = (8 << AXI_DATA_SIZE),
   parameter int MAX_BURST      = 16,
   parameter int ISSUE_LIMIT    = 4,
   parameter int SIZE_WIDTH     = 12
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   input  logic [AXI_ADDR_WIDTH-1:0] param_addr,
   input  logic [AXI_ADDR_WIDTH-1:0] param_stride,
   input  logic [SIZE_WIDTH-1:0]     param_hsize,
   input  logic [SIZE_WIDTH-1:0]     param_vsize,
   output logic [AXI_ID_WIDTH-1:0]   m_axi4_arid,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi4_araddr,
   output logic [AXI_LEN_WIDTH-1:0]  m_axi4_arlen,
   output logic [2:0]                m_axi4_arsize,
   output logic [1:0]                m_axi4_arburst,
   output logic                      m_axi4_arlock,
   output logic [3:0]                m_axi4_arcache,
   output logic [2:0]                m_axi4_arprot,
   output logic [3:0]                m_axi4_arqos,
   output logic                      m_axi4_arvalid,
   input  logic                      m_axi4_arready,
   input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
   input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
   input  logic [1:0]                m_axi4_rresp,
   input  logic                      m_axi4_rlast,
   input  logic                      m_axi4_rvalid,
   output logic                      m_axi4_rready,
   output logic [AXI_DATA_WIDTH-1:0] m_tdata,
   output logic                      m_tuser,
   output logic                      m_tlast,
   output logic                      m_tvalid,
   input  logic                      m_tready
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                    state_q, state_d;
   logic                      busy_q, busy_d, done_q, done_d;
   logic                      arvalid_q, arvalid_d;
   logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [AXI_LEN_WIDTH-1:0]  arlen_q, arlen_d;
   logic [AXI_ADDR_WIDTH-1:0] line_addr_q, line_addr_d, cur_addr_q, cur_addr_d, stride_q, stride_d;
   logic [SIZE_WIDTH-1:0]     hsize_q, hsize_d, rem_q, rem_d, lines_q, lines_d, beat_cnt_q, beat_cnt_d;
   logic [3:0]                outstanding_q, outstanding_d;
   logic                      first_q, first_d;

   logic                      ar_hs, r_hs, r_end;
   logic [AXI_LEN_WIDTH:0]    ar_beats;
   logic [31:0]               len_beats;
   logic [AXI_ADDR_WIDTH-1:0] next_line;
`ifdef AXI4_FRAME_READ_CTRL_4K_GUARD_EN
   logic [31:0]               to_4k;
`endif
   logic                      unused_r;

   assign unused_r = ^{m_axi4_rid, m_axi4_rresp};

   assign ar_hs     = arvalid_q && m_axi4_arready;
   assign r_hs      = m_axi4_rvalid && m_tready;
   assign r_end     = r_hs && m_axi4_rlast;
   assign ar_beats  = {1'b0, arlen_q} + 1'b1;
   assign next_line = line_addr_q + stride_q;

   always_comb begin
      state_d       = state_q;
      arvalid_d     = arvalid_q;
      araddr_d      = araddr_q;
      arlen_d       = arlen_q;
      line_addr_d   = line_addr_q;
      cur_addr_d    = cur_addr_q;
      stride_d      = stride_q;
      hsize_d       = hsize_q;
      rem_d         = rem_q;
      lines_d       = lines_q;
      beat_cnt_d    = beat_cnt_q;
      first_d       = first_q;
      outstanding_d = outstanding_q;

      len_beats = (32'(rem_q) < 32'(MAX_BURST)) ? 32'(rem_q) : 32'(MAX_BURST);
`ifdef AXI4_FRAME_READ_CTRL_4K_GUARD_EN
      to_4k = (32'd4096 - {20'd0, cur_addr_q[11:0]}) >> AXI_DATA_SIZE;
      if (to_4k < len_beats) len_beats = to_4k;
`endif

      case ({ar_hs, r_end})
         2'b10:   outstanding_d = outstanding_q + 4'd1;
         2'b01:   outstanding_d = outstanding_q - 4'd1;
         default: outstanding_d = outstanding_q;
      endcase

      // Line markers come from our own beat count so a slave's rlast placement cannot skew them.
      if (r_hs) begin
         first_d    = 1'b0;
         beat_cnt_d = (beat_cnt_q == hsize_q - 1'b1) ? '0 : beat_cnt_q + 1'b1;
      end

      case (state_q)
         IDLE: if (start) begin
            hsize_d     = param_hsize;
            stride_d    = param_stride;
            line_addr_d = param_addr;
            cur_addr_d  = param_addr;
            rem_d       = param_hsize;
            lines_d     = param_vsize;
            beat_cnt_d  = '0;
            first_d     = 1'b1;
            state_d     = (param_hsize == '0 || param_vsize == '0) ? DONE : ISSUE;
         end
         ISSUE: begin
            if (ar_hs) begin
               arvalid_d  = 1'b0;
               cur_addr_d = cur_addr_q + (AXI_ADDR_WIDTH'(ar_beats) << AXI_DATA_SIZE);
               rem_d      = rem_q - SIZE_WIDTH'(ar_beats);
               if (rem_q == SIZE_WIDTH'(ar_beats)) begin
                  line_addr_d = next_line;
                  cur_addr_d  = next_line;
                  rem_d       = hsize_q;
                  lines_d     = lines_q - 1'b1;
                  if (lines_q == SIZE_WIDTH'(1)) state_d = DRAIN;
               end
            end else if (!arvalid_q && outstanding_q < 4'(ISSUE_LIMIT)) begin
               arvalid_d = 1'b1;
               araddr_d  = cur_addr_q;
               arlen_d   = AXI_LEN_WIDTH'(len_beats - 32'd1);
            end
         end
         // Looking at the next count lets done follow the final beat by one cycle.
         DRAIN: if (outstanding_d == 4'd0) state_d = DONE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == ISSUE) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q       <= IDLE;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         arvalid_q     <= 1'b0;
         araddr_q      <= '0;
         arlen_q       <= '0;
         line_addr_q   <= '0;
         cur_addr_q    <= '0;
         stride_q      <= '0;
         hsize_q       <= '0;
         rem_q         <= '0;
         lines_q       <= '0;
         beat_cnt_q    <= '0;
         first_q       <= 1'b0;
         outstanding_q <= '0;
      end else begin
         state_q       <= state_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         arvalid_q     <= arvalid_d;
         araddr_q      <= araddr_d;
         arlen_q       <= arlen_d;
         line_addr_q   <= line_addr_d;
         cur_addr_q    <= cur_addr_d;
         stride_q      <= stride_d;
         hsize_q       <= hsize_d;
         rem_q         <= rem_d;
         lines_q       <= lines_d;
         beat_cnt_q    <= beat_cnt_d;
         first_q       <= first_d;
         outstanding_q <= outstanding_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign m_axi4_arid    = '0;
   assign m_axi4_araddr  = araddr_q;
   assign m_axi4_arlen   = arlen_q;
   assign m_axi4_arsize  = 3'(AXI_DATA_SIZE);
   assign m_axi4_arburst = 2'b01;
   assign m_axi4_arlock  = 1'b0;
   assign m_axi4_arcache = 4'b0011;
   assign m_axi4_arprot  = 3'b000;
   assign m_axi4_arqos   = 4'h0;
   assign m_axi4_arvalid = arvalid_q;
   assign m_axi4_rready  = m_tready;
   assign m_tdata        = m_axi4_rdata;
   assign m_tuser        = first_q;
   assign m_tlast        = (beat_cnt_q == hsize_q - 1'b1);
   assign m_tvalid       = m_axi4_rvalid;

endmodule

// File: tb/tb_axi4_frame_read_ctrl.sv
// Bench for axi4_frame_read_ctrl: memory slave returning rdata = beat address, queued AR/beat scoreboard.
module tb_axi4_frame_read_ctrl;

   typedef struct packed {logic [31:0] addr; logic [7:0] len;} ar_t;
   typedef struct packed {logic [31:0] data; logic user; logic last;} beat_t;
   typedef struct {logic [31:0] addr; logic [31:0] stride; int h; int v; bit rnd; int ars; int beats;} vec_t;

   logic        aclk, areset, start, busy, done;
   logic [31:0] param_addr, param_stride;
   logic [11:0] param_hsize, param_vsize;
   logic [3:0]  arid, arcache, arqos, rid;
   logic [31:0] araddr, rdata, tdata;
   logic [7:0]  arlen;
   logic [2:0]  arsize, arprot;
   logic [1:0]  arburst, rresp;
   logic        arlock, arvalid, arready, rlast, rvalid, rready;
   logic        tuser, tlast, tvalid, tready;

   int n_vec = 0, n_err = 0, cyc = 0;
   int ars_seen, beats_seen, done_cnt, done_cyc, last_cyc, outst;
   bit busy_seen, arv_seen, sb_off = 0, ar_rnd = 0;
   int tr_mode = 0;
   ar_t   exp_ar[$], rq[$];
   beat_t exp_bt[$];
   vec_t  tbl[8];

   axi4_frame_read_ctrl dut (
      .aclk(aclk), .areset(areset), .start(start), .busy(busy), .done(done),
      .param_addr(param_addr), .param_stride(param_stride),
      .param_hsize(param_hsize), .param_vsize(param_vsize),
      .m_axi4_arid(arid), .m_axi4_araddr(araddr), .m_axi4_arlen(arlen), .m_axi4_arsize(arsize),
      .m_axi4_arburst(arburst), .m_axi4_arlock(arlock), .m_axi4_arcache(arcache),
      .m_axi4_arprot(arprot), .m_axi4_arqos(arqos), .m_axi4_arvalid(arvalid),
      .m_axi4_arready(arready), .m_axi4_rid(rid), .m_axi4_rdata(rdata), .m_axi4_rresp(rresp),
      .m_axi4_rlast(rlast), .m_axi4_rvalid(rvalid), .m_axi4_rready(rready),
      .m_tdata(tdata), .m_tuser(tuser), .m_tlast(tlast), .m_tvalid(tvalid), .m_tready(tready)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial forever begin
      @(posedge aclk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference frame walk: lines of h beats at pitch s, each line cut at 16 beats (and at 4 KB when guarded).
   task automatic push_frame(input logic [31:0] a, input logic [31:0] s, input int h, input int v);
      logic [31:0] la, ca;
      int rem, bl;
      la = a;
      for (int l = 0; l < v; l++) begin
         ca  = la;
         rem = h;
         while (rem > 0) begin
            bl = (rem < 16) ? rem : 16;
`ifdef AXI4_FRAME_READ_CTRL_4K_GUARD_EN
            if ((4096 - int'(ca[11:0])) / 4 < bl) bl = (4096 - int'(ca[11:0])) / 4;
`endif
            exp_ar.push_back({ca, 8'(bl - 1)});
            ca  = ca + 32'(bl * 4);
            rem = rem - bl;
         end
         for (int b = 0; b < h; b++) exp_bt.push_back({la + 32'(b * 4), (l == 0 && b == 0), (b == h - 1)});
         la = la + s;
      end
   endtask

   // Ready drivers: sink ready and slave arready, steady or random.
   initial begin
      tready  = 1'b1;
      arready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         case (tr_mode)
            0:       tready = 1'b1;
            1:       tready = ($urandom_range(0, 3) != 0);
            default: tready = 1'b0;
         endcase
         arready = ar_rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   // Slave R channel: one burst at a time, data = address of the beat.
   initial begin
      ar_t cur;
      bit s_hs, s_rst, s_act;
      int s_idx;
      cur = '0; s_act = 0; s_idx = 0;
      rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = 4'h5; rresp = 2'b10;
      forever begin
         @(posedge aclk);
         s_hs  = rvalid && rready;
         s_rst = areset;
         #1;
         if (s_rst) begin
            rq.delete();
            s_act = 0;
         end else begin
            if (s_hs) begin
               if (s_idx == int'(cur.len)) s_act = 0;
               else s_idx++;
            end
            if (!s_act && rq.size() > 0) begin
               cur   = rq.pop_front();
               s_act = 1;
               s_idx = 0;
            end
         end
         rvalid = s_act;
         rdata  = cur.addr + 32'(s_idx * 4);
         rlast  = s_act && (s_idx == int'(cur.len));
      end
   end

   // Monitor and scoreboard, sampled mid-cycle.
   initial begin
      ar_t   e;
      beat_t eb;
      bit p_arv, p_ardy;
      logic [39:0] p_ar;
      p_arv = 0; p_ardy = 0; p_ar = '0; outst = 0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            p_arv = 0;
            outst = 0;
         end else begin
            if (arvalid) arv_seen = 1;
            if (busy) busy_seen = 1;
            if (p_arv && !p_ardy && !sb_off) begin
               chk("ar_hold_valid", 64'(arvalid), 64'(1));
               chk("ar_hold_fields", 64'({araddr, arlen}), 64'(p_ar));
            end
            p_arv = arvalid; p_ardy = arready; p_ar = {araddr, arlen};
            if (arvalid && arready) begin
               rq.push_back({araddr, arlen});
               ars_seen++;
               outst++;
               if (!sb_off) begin
                  chk("ar_fixed", 64'({arid, arsize, arburst, arlock, arcache, arprot, arqos}),
                      64'({4'h0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0}));
                  chk("ar_outstanding_cap", 64'(outst <= 4), 64'(1));
                  if (exp_ar.size() == 0) chk("ar_unexpected", 64'(exp_ar.size()), 64'(1));
                  else begin
                     e = exp_ar.pop_front();
                     chk("ar_addr", 64'(araddr), 64'(e.addr));
                     chk("ar_len", 64'(arlen), 64'(e.len));
                  end
               end
            end
            if (tvalid && tready) begin
               beats_seen++;
               if (rlast) outst--;
               if (!sb_off) begin
                  if (exp_bt.size() == 0) chk("beat_unexpected", 64'(exp_bt.size()), 64'(1));
                  else begin
                     eb = exp_bt.pop_front();
                     chk("tdata", 64'(tdata), 64'(eb.data));
                     chk("tuser", 64'(tuser), 64'(eb.user));
                     chk("tlast", 64'(tlast), 64'(eb.last));
                     if (exp_bt.size() == 0) last_cyc = cyc;
                  end
               end
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
         end
      end
   end

   task automatic start_frame(input logic [31:0] a, input logic [31:0] s, input int h, input int v);
      ars_seen = 0; beats_seen = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1;
      busy_seen = 0; arv_seen = 0;
      push_frame(a, s, h, v);
      param_addr = a; param_stride = s; param_hsize = 12'(h); param_vsize = 12'(v);
      start = 1'b1;
      @(posedge aclk);
      #1;
      start = 1'b0;
      param_addr = 32'hDEAD_BEE0; param_stride = 32'h0BAD_0000; param_hsize = 12'd3; param_vsize = 12'd7;
      if (h != 0 && v != 0) chk("busy_after_start", 64'(busy), 64'(1));
      else begin
         chk("empty_done_next_cycle", 64'(done), 64'(1));
         chk("empty_busy", 64'(busy), 64'(0));
      end
   endtask

   task automatic finish_frame(input int ea, input int eb);
      for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
         @(posedge aclk);
         #1;
      end
      chk("done_seen", 64'(done_cnt != 0), 64'(1));
      repeat (3) @(posedge aclk);
      #1;
      chk("done_once", 64'(done_cnt), 64'(1));
      chk("ar_count", 64'(ars_seen), 64'(ea));
      chk("beat_count", 64'(beats_seen), 64'(eb));
      chk("sb_ar_left", 64'(exp_ar.size()), 64'(0));
      chk("sb_beat_left", 64'(exp_bt.size()), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      if (eb != 0) chk("done_latency", 64'(done_cyc), 64'(last_cyc + 1));
      else begin
         chk("empty_never_busy", 64'(busy_seen), 64'(0));
         chk("empty_never_arvalid", 64'(arv_seen), 64'(0));
      end
   endtask

   initial begin
      tbl[0] = '{32'h0000_1000, 32'h100, 40, 2, 0, 6, 80};
      tbl[1] = '{32'h0000_2000, 32'h40, 16, 3, 0, 3, 48};
      tbl[2] = '{32'h0000_3000, 32'h20, 5, 4, 1, 4, 20};
      tbl[3] = '{32'hFFFF_FFF0, 32'h10, 4, 2, 0, 2, 8};
      tbl[4] = '{32'h0000_5000, 32'h200, 1, 3, 1, 3, 3};
      tbl[5] = '{32'h0000_6000, 32'h0, 17, 1, 0, 2, 17};
`ifdef AXI4_FRAME_READ_CTRL_4K_GUARD_EN
      tbl[6] = '{32'h0000_0FF8, 32'h100, 8, 1, 0, 2, 8};
`else
      tbl[6] = '{32'h0000_0FF8, 32'h100, 8, 1, 0, 1, 8};
`endif
      tbl[7] = '{32'h0000_7F00, 32'h1000, 33, 2, 1, 6, 66};

      areset = 1'b1; start = 1'b0;
      param_addr = '0; param_stride = '0; param_hsize = '0; param_vsize = '0;
      repeat (4) @(posedge aclk);
      #1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_arvalid", 64'(arvalid), 64'(0));
      chk("rst_tvalid", 64'(tvalid), 64'(0));
      areset = 1'b0;
      @(posedge aclk);
      #1;

      foreach (tbl[i]) begin
         tr_mode = tbl[i].rnd ? 1 : 0;
         ar_rnd  = tbl[i].rnd;
         start_frame(tbl[i].addr, tbl[i].stride, tbl[i].h, tbl[i].v);
         finish_frame(tbl[i].ars, tbl[i].beats);
      end
      tr_mode = 0; ar_rnd = 0;

      // Sink stalled: issue must stop at four outstanding bursts, then finish once the sink drains.
      tr_mode = 2;
      @(posedge aclk);
      #1;
      start_frame(32'h0000_2000, 32'h800, 160, 1);
      repeat (60) @(posedge aclk);
      #1;
      chk("stall_ar_count", 64'(ars_seen), 64'(4));
      chk("stall_arvalid", 64'(arvalid), 64'(0));
      chk("stall_beats", 64'(beats_seen), 64'(0));
      chk("stall_busy", 64'(busy), 64'(1));
      tr_mode = 0;
      finish_frame(10, 160);

      // Empty frame.
      start_frame(32'h0000_1234, 32'h4, 0, 5);
      finish_frame(0, 0);

      // Start while busy is ignored.
      start_frame(32'h0000_1000, 32'h100, 40, 2);
      repeat (5) @(posedge aclk);
      #1;
      param_addr = 32'h0000_8000; param_stride = 32'h40; param_hsize = 12'd8; param_vsize = 12'd1;
      start = 1'b1;
      @(posedge aclk);
      #1;
      start = 1'b0;
      chk("restart_busy", 64'(busy), 64'(1));
      finish_frame(6, 80);

      // Reset mid-frame, then a clean frame.
      start_frame(32'h0000_1000, 32'h100, 40, 2);
      for (int i = 0; i < 200 && ars_seen < 2; i++) begin
         @(posedge aclk);
         #1;
      end
      chk("rst_mid_two_ars", 64'(ars_seen >= 2), 64'(1));
      sb_off = 1;
      areset = 1'b1;
      @(posedge aclk);
      #1;
      areset = 1'b0;
      chk("rst_mid_arvalid", 64'(arvalid), 64'(0));
      chk("rst_mid_busy", 64'(busy), 64'(0));
      chk("rst_mid_done", 64'(done), 64'(0));
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_mid_no_done", 64'(done_cnt), 64'(0));
      chk("rst_mid_idle", 64'(busy), 64'(0));
      exp_ar.delete();
      exp_bt.delete();
      sb_off = 0;
      start_frame(32'h0000_1000, 32'h100, 40, 2);
      finish_frame(6, 80);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
